// File: rtl/dmem_uart_bridge.sv
// Data-memory stage: word RAM plus an MMIO page with a buffered 8N1 UART transmitter.
// Loads are combinational from the address; stores and all state updates happen on the rising clk edge.

module dmem_uart_bridge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Full is judged on the pre-edge count, so a push into a full FIFO is dropped
  // even when the same edge pops.
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module dmem_uart_bridge #(
  parameter int DEPTH        = 256,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] ALUResult,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        uart_tx
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Address decode
  logic          mmio_hit;
  logic          txdata_hit;
  logic          status_hit;
  logic [AW-1:0] ram_idx;
  logic          unused_addr;

  assign mmio_hit    = (ALUResult[31:8] == 24'hFFFFFF);
  assign txdata_hit  = mmio_hit & (ALUResult[7:0] == 8'h00);
  assign status_hit  = mmio_hit & (ALUResult[7:0] == 8'h04);
  assign ram_idx     = ALUResult[AW+1:2];
  assign unused_addr = ^ALUResult[1:0];

  // Word RAM, deliberately not reset so contents survive a bridge reset
  logic [31:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (MemWrite && !mmio_hit) ram[ram_idx] <= WriteData;
  end

  // TX FIFO
  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [FW:0]   fifo_count;

  assign fifo_push = MemWrite & txdata_hit;

  dmem_uart_bridge_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .rst_n    (Reset),
    .push     (fifo_push),
    .push_dat (WriteData[7:0]),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Sticky overflow; a same-edge set beats a software clear
  logic overflow;
  logic ovf_set;
  logic ovf_clr;

  assign ovf_set = fifo_push & fifo_full;
  assign ovf_clr = MemWrite & status_hit & WriteData[3];

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset)       overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  // Serialiser
  tx_state_t     state, state_n;
  logic [CW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          baud_done;

  assign baud_done = (baud_cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_n    = fifo_head;
          baud_cnt_n = '0;
          state_n    = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_cnt_n = '0;
          bit_idx_n  = 3'd0;
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt + CW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            shift_n   = {1'b0, shift[7:1]};
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_n = baud_cnt + CW'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_cnt_n = '0;
          state_n    = IDLE;
        end else begin
          baud_cnt_n = baud_cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level is computed from the next state so the registered output lines up with it
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'h00;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      uart_tx  <= tx_n;
    end
  end

  // Load path
  logic [31:0] status_word;

  assign status_word = {16'h0000, 8'(fifo_count), 4'h0,
                        overflow, fifo_empty, fifo_full, (state != IDLE)};

  always_comb begin
    ReadData = 32'h0000_0000;
    if (!mmio_hit)       ReadData = ram[ram_idx];
    else if (status_hit) ReadData = status_word;
  end
endmodule

// File: tb/tb_dmem_uart_bridge.sv
// Scoreboard bench for dmem_uart_bridge: loads and UART frames are checked by
// monitors against expectations queued by the directed stimulus.
module tb_dmem_uart_bridge;
  localparam logic [31:0] TXDATA = 32'hFFFF_FF00;
  localparam logic [31:0] STATUS = 32'hFFFF_FF04;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] ALUResult = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        uart_tx;

  dmem_uart_bridge #(
    .DEPTH        (256),
    .FIFO_DEPTH   (8),
    .CLKS_PER_BIT (4)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .ALUResult (ALUResult),
    .MemWrite  (MemWrite),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .uart_tx   (uart_tx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int tag_n = 0;

  typedef struct { logic [31:0] exp; int tag; } rd_t;
  typedef struct { logic [7:0] b; bit gap; } fr_t;
  rd_t rd_q[$];
  fr_t tx_q[$];
  logic rd_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic op(input logic we, input logic [31:0] a, input logic [31:0] d,
                    input bit chk, input logic [31:0] exp);
    @(posedge clk);
    #1;
    MemWrite  = we;
    ALUResult = a;
    WriteData = d;
    rd_chk    = chk;
    if (chk) begin
      rd_q.push_back('{exp, tag_n});
      tag_n++;
    end
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    op(1'b1, a, d, 1'b0, 32'h0);
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] exp);
    op(1'b0, a, 32'h0, 1'b1, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic expect_frame(input logic [7:0] b, input bit gap);
    tx_q.push_back('{b, gap});
  endtask

  // Load monitor
  always @(negedge clk) begin : rd_mon
    rd_t e;
    if (rd_chk && Reset) begin
      if (rd_q.size() == 0) begin
        check("load_queue_empty", 32'h1, 32'h0);
      end else begin
        e = rd_q.pop_front();
        check($sformatf("load%0d", e.tag), ReadData, e.exp);
      end
    end
  end

  // UART monitor: checks each of the 40 bit-cycles of a frame and the start-to-start spacing
  initial begin : tx_mon
    logic prev;
    logic want;
    int   cyc;
    int   start;
    int   last_start;
    int   errs;
    bit   aborted;
    bit   has_exp;
    fr_t  f;
    prev = 1'b1;
    cyc = 0;
    last_start = -1000;
    forever begin
      @(negedge clk);
      cyc++;
      if (!Reset) begin
        prev = 1'b1;
        continue;
      end
      if (prev && !uart_tx) begin
        start   = cyc;
        has_exp = (tx_q.size() != 0);
        f       = has_exp ? tx_q.pop_front() : '{8'h00, 1'b0};
        if (!has_exp) check($sformatf("unexpected_frame_at_cycle_%0d", cyc), 32'h1, 32'h0);
        errs    = 0;
        aborted = 1'b0;
        for (int i = 0; i < 40; i++) begin
          if (i > 0) begin
            @(negedge clk);
            cyc++;
          end
          if (!Reset) begin
            aborted = 1'b1;
            break;
          end
          if (i < 4)       want = 1'b0;
          else if (i < 36) want = f.b[(i-4)/4];
          else             want = 1'b1;
          if (uart_tx !== want) errs++;
        end
        if (!aborted && has_exp) begin
          check($sformatf("frame_%02h_badbits", f.b), errs, 0);
          if (f.gap) check($sformatf("frame_%02h_spacing", f.b), start - last_start, 41);
        end
        last_start = start;
        prev = aborted ? 1'b1 : uart_tx;
      end else begin
        prev = uart_tx;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_uart_tx", {31'h0, uart_tx}, 32'h1);
    Reset = 1'b1;
    ld(STATUS, 32'h0000_0004);

    // RAM, aliasing and byte-offset handling
    st(32'h10, 32'hDEAD_BEEF);
    ld(32'h10, 32'hDEAD_BEEF);
    ld(32'h410, 32'hDEAD_BEEF);
    ld(32'h13, 32'hDEAD_BEEF);
    st(32'h14, 32'h1234_5678);
    ld(32'h14, 32'h1234_5678);
    ld(32'h10, 32'hDEAD_BEEF);

    // Unmapped MMIO offset: no RAM write (0x308 shares its RAM index), no state change
    st(32'h308, 32'hCAFE_F00D);
    st(32'hFFFF_FF08, 32'hFFFF_FFFF);
    ld(32'hFFFF_FF08, 32'h0);
    ld(STATUS, 32'h0000_0004);
    ld(32'h308, 32'hCAFE_F00D);
    ld(TXDATA, 32'h0);

    // Single frame
    expect_frame(8'h55, 1'b0);
    st(TXDATA, 32'h0000_0055);
    ld(STATUS, 32'h0000_0100);
    ld(STATUS, 32'h0000_0005);
    idle(20);
    ld(STATUS, 32'h0000_0005);
    idle(25);
    ld(STATUS, 32'h0000_0004);

    // Back-to-back frames
    expect_frame(8'h41, 1'b0);
    expect_frame(8'h42, 1'b1);
    expect_frame(8'h43, 1'b1);
    st(TXDATA, 32'h41);
    st(TXDATA, 32'h42);
    st(TXDATA, 32'h43);
    ld(STATUS, 32'h0000_0201);
    idle(130);
    ld(STATUS, 32'h0000_0004);

    // Overflow: ten pushes, the tenth is dropped
    for (int i = 0; i < 9; i++) expect_frame(8'h60 + 8'(i), (i != 0));
    for (int i = 0; i < 10; i++) st(TXDATA, 32'h60 + i);
    ld(STATUS, 32'h0000_080B);
    st(STATUS, 32'h0000_0008);
    ld(STATUS, 32'h0000_0803);
    idle(380);
    ld(STATUS, 32'h0000_0004);

    // Reset during data bit 3 of the first of five queued bytes
    expect_frame(8'h70, 1'b0);
    for (int i = 0; i < 5; i++) st(TXDATA, 32'h70 + i);
    idle(14);
    check("tx_before_reset", {31'h0, uart_tx}, 32'h0);
    Reset = 1'b0;
    #1;
    check("tx_during_reset", {31'h0, uart_tx}, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    Reset = 1'b1;
    ld(STATUS, 32'h0000_0004);
    idle(100);
    ld(32'h10, 32'hDEAD_BEEF);
    idle(2);

    check("pending_frames", tx_q.size(), 0);
    check("pending_loads", rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
